// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_pkg;

    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        IMISS = 2'd1,
        DMISS = 2'd2
    } state_t;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Operand forwarding select for one E-stage source register.
// M-stage results win over W-stage results; x0 is never forwarded.
module forward_unit
    import hazard_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic [ADDR_WIDTH-1:0] rs,
    input  logic [ADDR_WIDTH-1:0] rd_m,
    input  logic                  reg_write_m,
    input  logic [ADDR_WIDTH-1:0] rd_w,
    input  logic                  reg_write_w,
    output logic [1:0]            sel
);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path infers a latch.
        sel = FWD_REG;
        if (reg_write_m && (rd_m != '0) && (rd_m == rs)) begin
            sel = FWD_MEM;
        end else if (reg_write_w && (rd_w != '0) && (rd_w == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush/forward controller for the 5-stage pipeline with a miss FSM and watchdog.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module hazard_controller
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_WIDTH = hazard_pkg::REG_ADDR_WIDTH,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int PERF_WIDTH     = 32
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2D_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs1E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rs2E_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdE_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdM_i,
    input  logic [REG_ADDR_WIDTH-1:0] rdW_i,
    input  logic                      regWriteM_i,
    input  logic                      regWriteW_i,
    input  logic                      loadE_i,
    input  logic                      pcSrcE_i,
    input  logic                      imemReady_i,
    input  logic                      memReqM_i,
    input  logic                      dmemReady_i,
    output logic                      stallF_o,
    output logic                      stallD_o,
    output logic                      stallE_o,
    output logic                      stallM_o,
    output logic                      flushD_o,
    output logic                      flushE_o,
    output logic                      flushW_o,
    output logic [1:0]                forwardAE_o,
    output logic [1:0]                forwardBE_o,
    output logic [1:0]                state_o,
    output logic                      timeout_o,
    output logic [PERF_WIDTH-1:0]     stallCycles_o,
    output logic [PERF_WIDTH-1:0]     flushCount_o
);

    localparam int               CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    state_t           state;
    logic [CNT_W-1:0] miss_cnt;
    logic             timeout;
    logic             data_miss;
    logic             fetch_miss;
    logic             load_use;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;

    forward_unit #(.ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_a (
        .rs          (rs1E_i),
        .rd_m        (rdM_i),
        .reg_write_m (regWriteM_i),
        .rd_w        (rdW_i),
        .reg_write_w (regWriteW_i),
        .sel         (fwd_a)
    );

    forward_unit #(.ADDR_WIDTH(REG_ADDR_WIDTH)) u_fwd_b (
        .rs          (rs2E_i),
        .rd_m        (rdM_i),
        .reg_write_m (regWriteM_i),
        .rd_w        (rdW_i),
        .reg_write_w (regWriteW_i),
        .sel         (fwd_b)
    );

    // A data wait is live until dmemReady_i is seen; the ready cycle itself releases.
    assign data_miss  = (state == DMISS) ? !dmemReady_i : (memReqM_i && !dmemReady_i);
    assign fetch_miss = !data_miss && !imemReady_i;
    assign load_use   = loadE_i && (rdE_i != '0) && ((rdE_i == rs1D_i) || (rdE_i == rs2D_i));

    always_comb begin
        stallF_o    = 1'b0;
        stallD_o    = 1'b0;
        stallE_o    = 1'b0;
        stallM_o    = 1'b0;
        flushD_o    = 1'b0;
        flushE_o    = 1'b0;
        flushW_o    = 1'b0;
        forwardAE_o = FWD_REG;
        forwardBE_o = FWD_REG;
        if (rst_i) begin
            flushD_o = 1'b1;
            flushE_o = 1'b1;
            flushW_o = 1'b1;
        end else begin
            forwardAE_o = fwd_a;
            forwardBE_o = fwd_b;
            if (data_miss) begin
                stallF_o = 1'b1;
                stallD_o = 1'b1;
                stallE_o = 1'b1;
                stallM_o = 1'b1;
                flushW_o = 1'b1;
            end else begin
                // A taken branch cancels the load-use hold so the redirect PC can load;
                // a held D register is never bubbled by a fetch miss.
                stallD_o = load_use && !pcSrcE_i;
                stallF_o = fetch_miss || (load_use && !pcSrcE_i);
                flushD_o = pcSrcE_i || (fetch_miss && !(load_use && !pcSrcE_i));
                flushE_o = pcSrcE_i || load_use;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
        if (rst_i) begin
            state    <= RUN;
            miss_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            unique case (state)
                RUN, IMISS: begin
                    if (memReqM_i && !dmemReady_i) state <= DMISS;
                    else if (!imemReady_i)         state <= IMISS;
                    else                           state <= RUN;
                end
                DMISS:   state <= dmemReady_i ? RUN : DMISS;
                default: state <= RUN;
            endcase

            if (state == RUN) begin
                miss_cnt <= '0;
            end else if (miss_cnt != CNT_MAX) begin
                miss_cnt <= miss_cnt + 1'b1;
                if (miss_cnt == CNT_MAX - 1'b1) timeout <= 1'b1;
            end
        end
    end

    assign state_o   = state;
    assign timeout_o = timeout;

`ifdef HAZARD_PERF_CNT_EN
    logic [PERF_WIDTH-1:0] stall_cycles;
    logic [PERF_WIDTH-1:0] flush_count;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            stall_cycles <= stall_cycles + PERF_WIDTH'(stallF_o);
            flush_count  <= flush_count + PERF_WIDTH'(flushE_o);
        end
    end

    assign stallCycles_o = stall_cycles;
    assign flushCount_o  = flush_count;
`else
    assign stallCycles_o = '0;
    assign flushCount_o  = '0;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench: directed scenarios plus random traffic against a rule-level model.
module tb_hazard_controller;

    localparam int AW   = 5;
    localparam int TMO  = 8;
    localparam int PW   = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic          regWriteM, regWriteW, loadE, pcSrcE, imemReady, memReqM, dmemReady;
    logic          stallF, stallD, stallE, stallM, flushD, flushE, flushW, timeout;
    logic [1:0]    forwardAE, forwardBE, state;
    logic [PW-1:0] stallCycles, flushCount;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model: what the pipeline is waiting for, and watchdog/perf bookkeeping.
    int            m_wait;   // 0 nothing, 1 fetch, 2 data
    int            m_miss;
    bit            m_to;
    logic [PW-1:0] m_stalls;
    logic [PW-1:0] m_flushes;

    hazard_controller #(.REG_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TMO), .PERF_WIDTH(PW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rs1D_i(rs1D), .rs2D_i(rs2D), .rs1E_i(rs1E), .rs2E_i(rs2E),
        .rdE_i(rdE), .rdM_i(rdM), .rdW_i(rdW),
        .regWriteM_i(regWriteM), .regWriteW_i(regWriteW),
        .loadE_i(loadE), .pcSrcE_i(pcSrcE), .imemReady_i(imemReady),
        .memReqM_i(memReqM), .dmemReady_i(dmemReady),
        .stallF_o(stallF), .stallD_o(stallD), .stallE_o(stallE), .stallM_o(stallM),
        .flushD_o(flushD), .flushE_o(flushE), .flushW_o(flushW),
        .forwardAE_o(forwardAE), .forwardBE_o(forwardBE),
        .state_o(state), .timeout_o(timeout),
        .stallCycles_o(stallCycles), .flushCount_o(flushCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_fwd(input logic [AW-1:0] rs);
        if (regWriteM && rdM != 0 && rdM == rs) return 2'b10;
        if (regWriteW && rdW != 0 && rdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    task automatic idle();
        rst = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
        regWriteM = 0; regWriteW = 0; loadE = 0; pcSrcE = 0;
        imemReady = 1; memReqM = 0; dmemReady = 1;
    endtask

    // Inputs are already applied; check at the negedge, then advance the model at the posedge.
    task automatic cycle(input string tag);
        bit sF, sD, sE, sM, fD, fE, fW, dwait, fwait, lu, hold;
        logic [1:0] fa, fb;
        logic [PW-1:0] exp_sc, exp_fc;
        @(negedge clk);
        {sF, sD, sE, sM, fD, fE, fW} = '0;
        fa = 2'b00; fb = 2'b00;
        if (rst) begin
            fD = 1; fE = 1; fW = 1;
        end else begin
            fa = exp_fwd(rs1E);
            fb = exp_fwd(rs2E);
            dwait = (m_wait == 2) ? !dmemReady : (memReqM && !dmemReady);
            if (dwait) begin
                sF = 1; sD = 1; sE = 1; sM = 1; fW = 1;
            end else begin
                fwait = !imemReady;
                lu    = loadE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
                hold  = lu && !pcSrcE;
                sF = fwait || hold;
                sD = hold;
                fD = pcSrcE || (fwait && !hold);
                fE = pcSrcE || lu;
            end
        end
`ifdef HAZARD_PERF_CNT_EN
        exp_sc = m_stalls;  exp_fc = m_flushes;
`else
        exp_sc = '0;        exp_fc = '0;
`endif
        chk({tag, ".ctrl"}, {stallF, stallD, stallE, stallM, flushD, flushE, flushW},
            {sF, sD, sE, sM, fD, fE, fW});
        chk({tag, ".fwd"}, {forwardAE, forwardBE}, {fa, fb});
        chk({tag, ".status"}, {state, timeout}, {m_wait[1:0], m_to});
        chk({tag, ".perf"}, {stallCycles, flushCount}, {exp_sc, exp_fc});
        @(posedge clk);
        if (rst) begin
            m_wait = 0; m_miss = 0; m_to = 0; m_stalls = '0; m_flushes = '0;
        end else begin
            m_stalls  += PW'(sF);
            m_flushes += PW'(fE);
            if (m_wait == 0) m_miss = 0;
            else begin
                if (m_miss < TMO) m_miss++;
                if (m_miss == TMO) m_to = 1;
            end
            if (m_wait == 2)                m_wait = dmemReady ? 0 : 2;
            else if (memReqM && !dmemReady) m_wait = 2;
            else if (!imemReady)            m_wait = 1;
            else                            m_wait = 0;
        end
        #1;
    endtask

    initial begin
        m_wait = 0; m_miss = 0; m_to = 0; m_stalls = '0; m_flushes = '0;
        idle();
        rst = 1;
        @(posedge clk); #1;
        cycle("reset");
        idle();
        cycle("idle");

        // Load-use, then the same with rdE = x0.
        loadE = 1; rdE = 5; rs1D = 5;
        cycle("load_use");
        chk("load_use.stallD", stallD, 1'b1);
        rdE = 0;
        cycle("load_use_x0");
        idle();

        // Forwarding priority.
        regWriteM = 1; regWriteW = 1; rdM = 7; rdW = 7; rs1E = 7;
        cycle("fwd_mem");
        chk("fwd_mem.a", forwardAE, 2'b10);
        rdM = 3;
        cycle("fwd_wb");
        rs1E = 0;
        cycle("fwd_x0");
        idle();

        // Branch overrides load-use.
        loadE = 1; rdE = 4; rs2D = 4; pcSrcE = 1;
        cycle("branch_lu");
        idle();

        // Data miss for 4 cycles, then ready.
        memReqM = 1; dmemReady = 0;
        for (int i = 0; i < 4; i++) cycle("dmiss");
        dmemReady = 1;
        cycle("dmiss_release");
        memReqM = 0;
        cycle("dmiss_after");
        chk("dmiss_after.state", state, 2'd0);

        // Instruction miss then data miss, held long enough for the watchdog.
        imemReady = 0;
        cycle("imiss");
        memReqM = 1; dmemReady = 0;
        for (int i = 0; i < TMO + 2; i++) cycle("watchdog");
        chk("watchdog.flag", timeout, 1'b1);
        dmemReady = 1; imemReady = 1;
        cycle("wd_release");
        idle();
        cycle("wd_sticky");
        chk("wd_sticky.flag", timeout, 1'b1);

        // Reset mid data miss.
        memReqM = 1; dmemReady = 0;
        cycle("pre_rst_dmiss");
        cycle("pre_rst_dmiss2");
        rst = 1;
        cycle("rst_mid");
        idle();
        cycle("rst_after");
        chk("rst_after.state", state, 2'd0);
        chk("rst_after.stallF", stallF, 1'b0);

        // Random traffic over a small register pool so hazards collide often.
        for (int i = 0; i < 400; i++) begin
            rst       = ($urandom_range(0, 99) == 0);
            rs1D      = AW'($urandom_range(0, 3));
            rs2D      = AW'($urandom_range(0, 3));
            rs1E      = AW'($urandom_range(0, 3));
            rs2E      = AW'($urandom_range(0, 3));
            rdE       = AW'($urandom_range(0, 3));
            rdM       = AW'($urandom_range(0, 3));
            rdW       = AW'($urandom_range(0, 3));
            regWriteM = 1'($urandom);
            regWriteW = 1'($urandom);
            loadE     = 1'($urandom);
            pcSrcE    = ($urandom_range(0, 3) == 0);
            imemReady = ($urandom_range(0, 3) != 0);
            memReqM   = ($urandom_range(0, 2) == 0);
            dmemReady = 1'($urandom);
            cycle("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
